// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down counter with wrap or saturate, clear, load and tc pulse.
// Define UPDOWN_COUNTER_STATUS_EN to add sticky overflow/underflow flags with clr_status.
module updown_counter_mod #(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 255,
   parameter bit WRAP    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_COUNTER_STATUS_EN
   input  logic             clr_status,
   output logic             ovf_sticky,
   output logic             unf_sticky,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;
   logic             r_tc;
   logic             w_tc;
   logic             w_at_max;
   logic             w_at_min;
   logic             w_up_evt;
   logic             w_dn_evt;

   always_comb begin
      w_at_max = (r_count == LP_MAX);
      w_at_min = (r_count == '0);
      w_up_evt = ~clear & ~load & en & mode & w_at_max;
      w_dn_evt = ~clear & ~load & en & ~mode & w_at_min;
      w_next   = r_count;
      w_tc     = 1'b0;
      if (clear) begin
         w_next = '0;
      end else if (load) begin
         w_next = (load_val > LP_MAX) ? LP_MAX : load_val;
      end else if (w_up_evt) begin
         w_tc   = 1'b1;
         w_next = WRAP ? '0 : LP_MAX;
      end else if (w_dn_evt) begin
         w_tc   = 1'b1;
         w_next = WRAP ? LP_MAX : '0;
      end else if (en) begin
         w_next = mode ? r_count + LP_ONE : r_count - LP_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc    <= w_tc;
      end
   end

`ifdef UPDOWN_COUNTER_STATUS_EN
   logic r_ovf;
   logic r_unf;

   // a new limit event beats clr_status on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_ovf <= w_up_evt | (r_ovf & ~clr_status);
         r_unf <= w_dn_evt | (r_unf & ~clr_status);
      end
   end

   assign ovf_sticky = r_ovf;
   assign unf_sticky = r_unf;
`endif

   assign count  = r_count;
   assign tc     = r_tc;
   assign at_max = w_at_max;
   assign at_min = w_at_min;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: vector table, corner sequences and random run against a reference model.
// Three instances: 4-bit mod-10 wrap, 4-bit mod-10 saturate, default 8-bit wrap.
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [7:0] lv8 = 8'd0;
   logic       clr_status = 1'b0;

   logic [3:0] c_a, c_b;
   logic [7:0] c_c;
   logic [2:0] tc_v, mx_v, mn_v;
   logic [2:0] ovf_v, unf_v;

   int n_total = 0;
   int n_pass = 0;

   int m_cnt[3];
   int m_tc[3];
   int m_ovf[3];
   int m_unf[3];
   int maxv[3] = '{9, 9, 255};
   int wrapv[3] = '{1, 0, 1};

   always #5 clk = ~clk;

   updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .WRAP(1'b1)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear),
      .load(load), .load_val(lv8[3:0]),
`ifdef UPDOWN_COUNTER_STATUS_EN
      .clr_status(clr_status), .ovf_sticky(ovf_v[0]), .unf_sticky(unf_v[0]),
`endif
      .count(c_a), .tc(tc_v[0]), .at_max(mx_v[0]), .at_min(mn_v[0]));

   updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .WRAP(1'b0)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear),
      .load(load), .load_val(lv8[3:0]),
`ifdef UPDOWN_COUNTER_STATUS_EN
      .clr_status(clr_status), .ovf_sticky(ovf_v[1]), .unf_sticky(unf_v[1]),
`endif
      .count(c_b), .tc(tc_v[1]), .at_max(mx_v[1]), .at_min(mn_v[1]));

   updown_counter_mod u_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear),
      .load(load), .load_val(lv8),
`ifdef UPDOWN_COUNTER_STATUS_EN
      .clr_status(clr_status), .ovf_sticky(ovf_v[2]), .unf_sticky(unf_v[2]),
`endif
      .count(c_c), .tc(tc_v[2]), .at_max(mx_v[2]), .at_min(mn_v[2]));

`ifndef UPDOWN_COUNTER_STATUS_EN
   assign ovf_v = '0;
   assign unf_v = '0;
`endif

   task automatic chk(input string name, input int got, input int want);
      n_total++;
      if (got == want) n_pass++;
      else $display("FAIL %s got=%0d want=%0d", name, got, want);
   endtask

   function automatic int act_cnt(input int i);
      case (i)
         0: return int'(c_a);
         1: return int'(c_b);
         default: return int'(c_c);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         int v;
         int up_e, dn_e;
         up_e = 0; dn_e = 0;
         v = (i == 2) ? int'(lv8) : int'(lv8[3:0]);
         m_tc[i] = 0;
         if (clear) m_cnt[i] = 0;
         else if (load) m_cnt[i] = (v > maxv[i]) ? maxv[i] : v;
         else if (en && mode) begin
            if (m_cnt[i] < maxv[i]) m_cnt[i]++;
            else begin
               m_tc[i] = 1; up_e = 1;
               m_cnt[i] = wrapv[i] ? 0 : maxv[i];
            end
         end else if (en) begin
            if (m_cnt[i] > 0) m_cnt[i]--;
            else begin
               m_tc[i] = 1; dn_e = 1;
               m_cnt[i] = wrapv[i] ? maxv[i] : 0;
            end
         end
         m_ovf[i] = (up_e != 0 || (m_ovf[i] != 0 && !clr_status)) ? 1 : 0;
         m_unf[i] = (dn_e != 0 || (m_unf[i] != 0 && !clr_status)) ? 1 : 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s.cnt%0d", tag, i), act_cnt(i), m_cnt[i]);
         chk($sformatf("%s.tc%0d", tag, i), int'(tc_v[i]), m_tc[i]);
         chk($sformatf("%s.max%0d", tag, i), int'(mx_v[i]),
             (m_cnt[i] == maxv[i]) ? 1 : 0);
         chk($sformatf("%s.min%0d", tag, i), int'(mn_v[i]),
             (m_cnt[i] == 0) ? 1 : 0);
`ifdef UPDOWN_COUNTER_STATUS_EN
         chk($sformatf("%s.ovf%0d", tag, i), int'(ovf_v[i]), m_ovf[i]);
         chk($sformatf("%s.unf%0d", tag, i), int'(unf_v[i]), m_unf[i]);
`endif
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      if (rst) model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic c, input logic l, input logic e,
                        input logic m, input int v);
      clear = c; load = l; en = e; mode = m; lv8 = 8'(v);
   endtask

   typedef struct {
      logic clr;
      logic ld;
      logic en;
      logic md;
      int   lv;
      int   exp_cnt;
      int   exp_tc;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // wrap up 0..9,0,1,2 on the mod-10 counter
      for (int k = 1; k <= 12; k++)
         tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 0, k % 10, (k == 10) ? 1 : 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 0, 9, 1});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 14, 9, 0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5, 0, 0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 5, 5, 0});
      for (int k = 0; k < 5; k++)
         tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 0, 5, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 0, 6, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 0, 5, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 0, 6, 0});

      model_reset();
      #2;
      check_all("reset");
      #10;
      rst = 1'b1;

      foreach (tbl[k]) begin
         drive(tbl[k].clr, tbl[k].ld, tbl[k].en, tbl[k].md, tbl[k].lv);
         cyc($sformatf("vec%0d", k));
         chk($sformatf("vec%0d.cntA", k), int'(c_a), tbl[k].exp_cnt);
         chk($sformatf("vec%0d.tcA", k), int'(tc_v[0]), tbl[k].exp_tc);
      end

      // saturating down from 0: holds 0 with tc high every cycle
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
      cyc("sat_clr");
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc($sformatf("sat%0d", k));
         chk($sformatf("sat%0d.cntB", k), int'(c_b), 0);
         chk($sformatf("sat%0d.tcB", k), int'(tc_v[1]), 1);
      end

      // asynchronous reset mid-count at 37
      drive(1'b0, 1'b1, 1'b0, 1'b1, 37);
      cyc("ld37");
      chk("ld37.cntC", int'(c_c), 37);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      chk("arst.cntC", int'(c_c), 0);
      chk("arst.tcC", int'(tc_v[2]), 0);
      chk("arst.minC", int'(mn_v[2]), 1);
      check_all("arst");
      @(negedge clk);
      rst = 1'b1;
      cyc("resume");
      chk("resume.cntC", int'(c_c), 1);

`ifdef UPDOWN_COUNTER_STATUS_EN
      drive(1'b0, 1'b1, 1'b0, 1'b1, 9);
      clr_status = 1'b1;
      cyc("st_ld");
      clr_status = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
      cyc("st_ovf");
      chk("st_ovf.ovfA", int'(ovf_v[0]), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
      for (int k = 0; k < 20; k++) cyc("st_hold");
      chk("st_hold.ovfA", int'(ovf_v[0]), 1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
      clr_status = 1'b1;
      cyc("st_unf");
      clr_status = 1'b0;
      chk("st_unf.cntA", int'(c_a), 9);
      chk("st_unf.unfA", int'(unf_v[0]), 1);
      chk("st_unf.ovfA", int'(ovf_v[0]), 0);
`endif

      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) != 0), 1'($urandom),
               int'($urandom_range(0, 255)));
         clr_status = ($urandom_range(0, 15) == 0);
         cyc($sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised successor to the team's fixed 8-bit up/down counter.
- Adds configurable width and modulus, wrap or saturate at the limits, count enable, synchronous clear, parallel load, and a registered terminal-count pulse.
- Used as a general-purpose event, timer or index counter in datapath and control blocks.

Parameters:
- WIDTH, 8: counter width in bits; must be >= 2.
- MAX_VAL, 255: top count value; count range is 0..MAX_VAL; 1 <= MAX_VAL <= 2**WIDTH-1.
- WRAP, 1: limit behaviour. 1 = modulo (wrap-around); 0 = saturate.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; the counter steps only when en=1.
- mode  input  1  direction. 1 = up, 0 = down.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  current count (registered).
- tc  output  1  registered terminal-count pulse.
- at_max  output  1  decode of count==MAX_VAL.
- at_min  output  1  decode of count==0.

Behaviour:
- Reset (rst=0, asynchronous): count=0, tc=0; status registers cleared if compiled in. at_min=1, at_max=0 follow from count.
- Release of rst takes effect on the first rising clk edge after deassertion.
- Per-edge priority, highest first: clear > load > en. Only one action occurs per edge.
- clear=1: count<=0, tc<=0; load, en and mode are ignored.
- load=1 (clear=0): count<=load_val, tc<=0.
  - If load_val>MAX_VAL, count<=MAX_VAL (clamped).
  - Load does not generate tc.
- en=1, mode=1 (up):
  - count<MAX_VAL: count<=count+1, tc<=0.
  - count==MAX_VAL, WRAP=1: count<=0, tc<=1.
  - count==MAX_VAL, WRAP=0: count holds MAX_VAL, tc<=1.
- en=1, mode=0 (down):
  - count>0: count<=count-1, tc<=0.
  - count==0, WRAP=1: count<=MAX_VAL, tc<=1.
  - count==0, WRAP=0: count holds 0, tc<=1.
- en=0 with no clear or load: count holds, tc<=0.
- tc is a single-cycle pulse, high in the cycle after the limit event.
  - It stays high on consecutive cycles only while limit events repeat (e.g. saturated with en=1 held).
- Arithmetic is WIDTH bits with no carry output.
- MAX_VAL<2**WIDTH-1 wraps at the modulus, not at the natural width rollover.
- count is never outside 0..MAX_VAL in any state.
- A direction change mid-count takes effect on the next enabled edge with no bubble.
- Reset asserted mid-operation forces the reset values immediately, regardless of clk.
- at_max and at_min are combinational decodes of the count register only; they are glitch-free relative to clk.

Optional Feature:
- Macro: UPDOWN_COUNTER_STATUS_EN.
- Defined: adds two outputs and one input.
  - ovf_sticky (output, 1): set on any up-direction limit event.
  - unf_sticky (output, 1): set on any down-direction limit event.
  - clr_status (input, 1): synchronous clear of both sticky bits.
  - Both sticky bits hold until clr_status=1 or rst=0.
  - If clr_status and a new event occur on the same edge, set wins and the bit stays 1.
  - clear and load do not affect the sticky bits.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=0 mid-count at count=37, asynchronous to clk -> count=0, tc=0, at_min=1 immediately; counting resumes from 0 after release.
- Wrap up: WIDTH=4, MAX_VAL=9, WRAP=1, en=1, mode=1 for 12 edges from 0 -> count 1..9,0,1,2; tc=1 only in the cycle after the 9->0 edge.
- Wrap down and saturate: WRAP=1, mode=0 from count=0 -> count=9, tc pulse. WRAP=0, mode=0 from count=0 held for 3 edges -> count stays 0, tc=1 for all 3 cycles.
- Priority and clamp: MAX_VAL=9, load_val=14, load=1, en=1 -> count=9, tc=0. Then clear=1 with load=1 -> count=0.
- Hold and direction change: en=0 for 5 edges at count=5 -> count stays 5. mode toggled 1,0,1 with en=1 -> count 6,5,6.
- UPDOWN_COUNTER_STATUS_EN: wrap 9->0 -> ovf_sticky=1, held after 20 further edges. clr_status=1 on the same edge as a 0->9 underflow -> unf_sticky=1, ovf_sticky=0.
